// File: rtl/q_value_select.sv
// Streaming arg-max/arg-min over a frame of IEEE-754 Q-values.
// Total ordering is a sign-folded integer key with NaN handled out of band.
module q_value_select #(
    parameter int DATA_WIDTH            = 32,
    parameter int EXP_WIDTH             = 8,
    parameter int NUMBER_OF_OUTPUT_NODE = 3,
    parameter int INDEX_WIDTH           = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_mode,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [INDEX_WIDTH-1:0] o_index,
    output logic                   o_all_nan,
    output logic                   o_valid,
    output logic                   o_busy
);

    localparam int MANT_WIDTH = DATA_WIDTH - EXP_WIDTH - 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);
    localparam logic [DATA_WIDTH-1:0]  SIGN_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam bit SINGLE = (NUMBER_OF_OUTPUT_NODE == 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state_reg, state_next;
    logic [INDEX_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]   best_reg, best_next;
    logic [INDEX_WIDTH-1:0]  best_idx_reg, best_idx_next;
    logic                    best_nan_reg, best_nan_next;
    logic                    mode_reg, mode_next;
    logic                    finish;

    logic                    in_nan;
    logic [DATA_WIDTH-1:0]   in_key, best_key;
    logic                    better, take_new;

    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
        return (&x[DATA_WIDTH-2 -: EXP_WIDTH]) && (|x[MANT_WIDTH-1:0]);
    endfunction

    // -0 folds onto +0 so the two zeros tie and the earlier index wins.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] v;
        v = (x == SIGN_BIT) ? '0 : x;
        return v[DATA_WIDTH-1] ? ~v : (v ^ SIGN_BIT);
    endfunction

    always_comb begin
        in_nan   = is_nan(i_data);
        in_key   = order_key(i_data);
        best_key = order_key(best_reg);
        better   = mode_reg ? (in_key < best_key) : (in_key > best_key);
        // A NaN best yields to any number; a NaN never displaces a number.
        take_new = best_nan_reg ? !in_nan : (!in_nan && better);
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        best_next     = best_reg;
        best_idx_next = best_idx_reg;
        best_nan_next = best_nan_reg;
        mode_next     = mode_reg;
        finish        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_valid) begin
                    best_next     = i_data;
                    best_idx_next = '0;
                    best_nan_next = in_nan;
                    mode_next     = i_mode;
                    if (SINGLE) begin
                        finish   = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next   = INDEX_WIDTH'(1);
                        state_next = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (i_valid) begin
                    if (take_new) begin
                        best_next     = i_data;
                        best_idx_next = cnt_reg;
                        best_nan_next = in_nan;
                    end
                    if (cnt_reg == LAST_IDX) begin
                        finish     = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + INDEX_WIDTH'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            best_reg     <= '0;
            best_idx_reg <= '0;
            best_nan_reg <= 1'b0;
            mode_reg     <= 1'b0;
            o_data       <= '0;
            o_index      <= '0;
            o_all_nan    <= 1'b0;
            o_valid      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            best_reg     <= best_next;
            best_idx_reg <= best_idx_next;
            best_nan_reg <= best_nan_next;
            mode_reg     <= mode_next;
            o_valid      <= finish;
            if (finish) begin
                o_data    <= best_next;
                o_index   <= best_idx_next;
                o_all_nan <= best_nan_next;
            end
        end
    end

    assign o_busy = (state_reg == ACCUM);

endmodule

// File: tb/tb_q_value_select.sv
// Scoreboard bench for q_value_select: expected results are queued as each
// frame's last element is driven and compared when o_valid pulses.
module tb_q_value_select;

    localparam int N = 3;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_mode;
    logic [31:0] o_data;
    logic [1:0]  o_index;
    logic        o_all_nan;
    logic        o_valid;
    logic        o_busy;

    q_value_select #(
        .DATA_WIDTH(32), .EXP_WIDTH(8), .NUMBER_OF_OUTPUT_NODE(N), .INDEX_WIDTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_mode(i_mode),
        .o_data(o_data), .o_index(o_index), .o_all_nan(o_all_nan),
        .o_valid(o_valid), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  idx;
        logic        all_nan;
    } result_t;

    result_t sb[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    int tb_cnt       = 0;
    logic exp_valid  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ordering built from sign/magnitude, independent of key folding.
    function automatic logic m_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic m_less(input logic [31:0] a, input logic [31:0] b);
        logic sa, sb_;
        sa  = a[31] && (a[30:0] != 31'd0);
        sb_ = b[31] && (b[30:0] != 31'd0);
        if (sa != sb_) return sa;
        if (!sa) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    function automatic result_t model(input logic [31:0] e0, e1, e2, input logic mode);
        logic [31:0] e [N];
        result_t r;
        logic nn, better;
        e[0] = e0; e[1] = e1; e[2] = e2;
        r.data = e[0]; r.idx = 2'd0; r.all_nan = m_nan(e[0]);
        for (int k = 1; k < N; k++) begin
            nn = m_nan(e[k]);
            better = mode ? m_less(e[k], r.data) : m_less(r.data, e[k]);
            if (r.all_nan ? !nn : (!nn && better)) begin
                r.data = e[k]; r.idx = 2'(k); r.all_nan = nn;
            end
        end
        return r;
    endfunction

    // Reference frame position tracker for o_busy / o_valid timing.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_cnt    = 0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = i_valid && (tb_cnt == N - 1);
            if (i_valid) tb_cnt = (tb_cnt + 1) % N;
        end
    end

    always @(posedge clk) begin
        result_t r;
        #1;
        if (rst_n) begin
            check("o_busy", 32'(o_busy), 32'(tb_cnt != 0));
            check("o_valid", 32'(o_valid), 32'(exp_valid));
            if (o_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(o_valid), 32'd0);
                end else begin
                    r = sb.pop_front();
                    $display("result data=%h idx=%0d all_nan=%0b (exp %h/%0d/%0b)",
                             o_data, o_index, o_all_nan, r.data, r.idx, r.all_nan);
                    check("o_data", o_data, r.data);
                    check("o_index", 32'(o_index), 32'(r.idx));
                    check("o_all_nan", 32'(o_all_nan), 32'(r.all_nan));
                end
            end
        end
    end

    task automatic drive_elem(input logic [31:0] d, input logic m);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        i_mode  = m;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_data  = $urandom;
        end
    endtask

    task automatic send_frame(input logic [31:0] e0, e1, e2, input logic mode,
                              input int gap, input logic toggle);
        logic [31:0] e [N];
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int k = 0; k < N; k++) begin
            if (k > 0) idle(gap);
            if (k == N - 1) sb.push_back(model(e0, e1, e2, mode));
            drive_elem(e[k], (k == 0) ? mode : (mode ^ toggle));
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] pool [8];
        pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00000, 32'h3F800000, 32'hBF800000, 32'h40000000};
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 7)];
        return $urandom;
    endfunction

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_o_data", o_data, 32'd0);
        check("rst_o_index", 32'(o_index), 32'd0);
        check("rst_o_all_nan", 32'(o_all_nan), 32'd0);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_busy", 32'(o_busy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        send_frame(32'h3F800000, 32'h40000000, 32'hC0400000, 1'b0, 0, 1'b0);
        send_frame(32'h3F800000, 32'h40000000, 32'hC0400000, 1'b1, 0, 1'b1);
        send_frame(32'h40000000, 32'h40000000, 32'h3F800000, 1'b0, 0, 1'b0);
        send_frame(32'h80000000, 32'h00000000, 32'hBF800000, 1'b0, 0, 1'b0);
        send_frame(32'h7FC00000, 32'h3F000000, 32'hBF800000, 1'b0, 0, 1'b0);
        send_frame(32'h7FC00000, 32'hFFC00001, 32'h7F800001, 1'b0, 0, 1'b0);
        send_frame(32'h3F800000, 32'hFF800000, 32'h7F800000, 1'b1, 3, 1'b0);
        idle(2);
        for (int f = 0; f < 8; f++)
            send_frame(pick(), pick(), pick(), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        idle(3);

        drive_elem(32'h41000000, 1'b0);
        drive_elem(32'h42000000, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_o_data", o_data, 32'd0);
        check("midrst_o_index", 32'(o_index), 32'd0);
        check("midrst_o_all_nan", 32'(o_all_nan), 32'd0);
        check("midrst_o_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_frame(32'hBF800000, 32'hC0000000, 32'h3F800000, 1'b0, 0, 1'b0);
        idle(2);

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
